rv32i_hazard_scoreboard: RTL and testbench
==========================================

Name: rv32i_hazard_scoreboard

Overview:
- Parametrised successor to the fixed `forwarding_unit` / ad-hoc stall/flush wiring of the 5-stage RV32I core.
- Per-register countdown scoreboard tracks in-flight results with variable producer latency (ALU, load, future multi-cycle ops).
- Generates IF/ID stall, ID/EX bubble, branch/jump flushes, and a global freeze while data memory has not acknowledged.
- Sits beside ID; drives `stall`/`flush` of `id_ex_pipeline_reg` and the PC/IF-ID registers.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- RIDX_W, 5, register index width; must equal clog2(NREG).
- LAT_W, 3, width of each countdown counter.
- MAX_LAT, 4, largest accepted producer latency; must satisfy MAX_LAT < 2^LAT_W.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  RIDX_W each  source register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction reads that source.
- id_rd  in  RIDX_W  destination register index.
- id_reg_write  in  1  instruction writes rd.
- id_lat  in  LAT_W  cycles from issue until the result is forwardable (1=ALU, 2=load).
- ex_redirect  in  1  taken branch/jump/jalr resolved in EX.
- mem_req  in  1  MEM stage is accessing data memory this cycle.
- mem_ack  in  1  data memory completes the access this cycle.
- stall_if  out  1  hold PC and the IF/ID register.
- stall_id  out  1  hold the ID stage.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_id  out  1  squash IF/ID.
- flush_ex  out  1  squash ID/EX.
- freeze  out  1  hold every pipeline register.
- issue_fire  out  1  the instruction in ID advances to EX this cycle.
- busy  out  1  at least one counter is nonzero.

Behaviour:
- State: cnt[1..NREG-1], each LAT_W bits. cnt[0] is constantly 0.
- On reset low: all cnt cleared immediately (async). Reset values of all outputs: 0, given id_valid=0 and mem_req=0. This also holds when reset is asserted mid-operation.
- freeze = mem_req & ~mem_ack (combinational). A same-cycle ack gives zero freeze cycles.
- hazard = id_valid & ((id_use_rs1 & id_rs1!=0 & cnt[id_rs1]>1) | (id_use_rs2 & id_rs2!=0 & cnt[id_rs2]>1)).
  - cnt==1 means the value is forwardable via EX/MEM and produces no stall.
- Priority: freeze > ex_redirect > hazard.
  - freeze=1: stall_if=stall_id=1; bubble_ex, flush_id, flush_ex, issue_fire all 0; counters hold.
  - Source of ex_redirect keeps it asserted until freeze drops.
- ex_redirect & ~freeze: flush_id=flush_ex=1; issue_fire=0; stall_*=0; no counter load.
- hazard & ~freeze & ~ex_redirect: stall_if=stall_id=bubble_ex=1; issue_fire=0.
- issue_fire = id_valid & ~hazard & ~ex_redirect & ~freeze.
- Sequential update, when ~freeze:
  - Every cnt>0 decrements by 1.
  - If issue_fire & id_reg_write & id_rd!=0: cnt[id_rd] <= eff_lat, overriding that register's decrement.
  - eff_lat = min(id_lat, MAX_LAT), and id_lat=0 is treated as 1.
- Hazard uses pre-update counts, so an instruction whose rd equals its own rs does not self-stall.
- busy = OR of all cnt.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles [31:0], perf_flushes [31:0] and perf_freeze_cycles [31:0].
  - Each increments on the cycle its condition is asserted: hazard stall, redirect flush, freeze.
  - All saturate at 0xFFFFFFFF and are cleared by reset.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: issue x5 with lat=2, next cycle rs1=x5 -> one cycle of stall_if=stall_id=bubble_ex=1, then issue_fire=1.
- ALU back-to-back: issue x6 with lat=1, next cycle rs2=x6 -> no stall, issue_fire=1 on both cycles.
- x0 / clamp: rd=x0 with lat=2 -> busy stays 0. rd=x7 with id_lat=7 -> x7 consumer stalls exactly 3 cycles (MAX_LAT=4).
- Redirect during hazard: ex_redirect=1 with a load-use pending -> flush_id=flush_ex=1, bubble_ex=0, issue_fire=0.
- Freeze: mem_req=1, mem_ack=0 for 3 cycles with x5 cnt=2 -> freeze=1 for 3 cycles, cnt[5] stays 2, then decrements to 1 after ack.
- Async reset mid-run: drop reset with cnt[9]=3 -> busy=0 immediately; a consumer of x9 issues with no stall after release.

Source files
------------

// File: rtl/rv32i_hazard_scoreboard.sv
// Per-register countdown scoreboard generating stall/bubble/flush/freeze for the RV32I pipeline.
// Optional performance counters are built in when HAZARD_PERF_CNT_EN is defined.
module rv32i_hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int RIDX_W  = 5,
  parameter int LAT_W   = 3,
  parameter int MAX_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic [LAT_W-1:0]  id_lat,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              freeze,
  output logic              issue_fire,
  output logic              busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flushes,
  output logic [31:0]       perf_freeze_cycles
`endif
);

  logic [LAT_W-1:0] cnt [NREG];
  logic [LAT_W-1:0] eff_lat;
  logic             hazard;
  logic             rs1_pending;
  logic             rs2_pending;
  logic             load_en;

  // A count of 1 means the result is already forwardable, so only >1 stalls.
  assign rs1_pending = id_use_rs1 && (id_rs1 != '0) && (cnt[id_rs1] > LAT_W'(1));
  assign rs2_pending = id_use_rs2 && (id_rs2 != '0) && (cnt[id_rs2] > LAT_W'(1));
  assign hazard      = id_valid && (rs1_pending || rs2_pending);

  assign freeze     = mem_req && !mem_ack;
  assign flush_id   = !freeze && ex_redirect;
  assign flush_ex   = !freeze && ex_redirect;
  assign bubble_ex  = !freeze && !ex_redirect && hazard;
  assign stall_if   = freeze || bubble_ex;
  assign stall_id   = freeze || bubble_ex;
  assign issue_fire = id_valid && !hazard && !ex_redirect && !freeze;
  assign load_en    = issue_fire && id_reg_write && (id_rd != '0);

  always_comb begin
    eff_lat = id_lat;
    if (id_lat == '0)
      eff_lat = LAT_W'(1);
    else if (id_lat > LAT_W'(MAX_LAT))
      eff_lat = LAT_W'(MAX_LAT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
    end else if (!freeze) begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (load_en && (id_rd == RIDX_W'(r)))
          cnt[r] <= eff_lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NREG; r++)
      busy = busy | (cnt[r] != '0);
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters; they never wrap back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles  <= '0;
      perf_flushes       <= '0;
      perf_freeze_cycles <= '0;
    end else begin
      if (bubble_ex && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush_ex && (perf_flushes != '1))
        perf_flushes <= perf_flushes + 32'd1;
      if (freeze && (perf_freeze_cycles != '1))
        perf_freeze_cycles <= perf_freeze_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_hazard_scoreboard.sv
// Directed bench for rv32i_hazard_scoreboard; outputs are checked as one packed vector
// {stall_if, stall_id, bubble_ex, flush_id, flush_ex, freeze, issue_fire, busy}.
module tb_rv32i_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic [2:0] id_lat;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ack;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       flush_id;
  logic       flush_ex;
  logic       freeze;
  logic       issue_fire;
  logic       busy;
  logic [7:0] outs;

  int n_checks;
  int n_fail;

  rv32i_hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_lat       (id_lat),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex),
    .flush_id     (flush_id),
    .flush_ex     (flush_ex),
    .freeze       (freeze),
    .issue_fire   (issue_fire),
    .busy         (busy)
  );

  assign outs = {stall_if, stall_id, bubble_ex, flush_id, flush_ex, freeze, issue_fire, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wr, input logic [2:0] lat);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_lat = lat;
  endtask

  task automatic set_idle();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    @(negedge clk); #1;
    n_checks++;
    if (outs !== 8'b0000_0000) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, 8'b0000_0000); end
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk); drive_id(1, 0, 0, 0, 0, 5, 1, 2); #1;
    n_checks++;
    if (outs !== 8'b0000_0010) begin n_fail++; $display("FAIL lu_issue_prod: got %b want %b", outs, 8'b0000_0010); end
    @(negedge clk); drive_id(1, 5, 1, 0, 0, 0, 0, 1); #1;
    n_checks++;
    if (outs !== 8'b1110_0001) begin n_fail++; $display("FAIL lu_stall: got %b want %b", outs, 8'b1110_0001); end
    @(negedge clk); #1;
    n_checks++;
    if (outs !== 8'b0000_0011) begin n_fail++; $display("FAIL lu_consumer_issue: got %b want %b", outs, 8'b0000_0011); end
    @(negedge clk); set_idle(); #1;
    n_checks++;
    if (outs !== 8'b0000_0000) begin n_fail++; $display("FAIL lu_drain: got %b want %b", outs, 8'b0000_0000); end
  endtask

  // Second instruction reads x6 and rewrites it: no self-stall, new latency then applies.
  task automatic test_alu_back_to_back();
    @(negedge clk); drive_id(1, 0, 0, 0, 0, 6, 1, 1); #1;
    n_checks++;
    if (outs !== 8'b0000_0010) begin n_fail++; $display("FAIL alu_issue_prod: got %b want %b", outs, 8'b0000_0010); end
    @(negedge clk); drive_id(1, 0, 0, 6, 1, 6, 1, 2); #1;
    n_checks++;
    if (outs !== 8'b0000_0011) begin n_fail++; $display("FAIL alu_b2b_issue: got %b want %b", outs, 8'b0000_0011); end
    @(negedge clk); drive_id(1, 6, 1, 0, 0, 0, 0, 1); #1;
    n_checks++;
    if (outs !== 8'b1110_0001) begin n_fail++; $display("FAIL alu_rewrite_stall: got %b want %b", outs, 8'b1110_0001); end
    @(negedge clk); #1;
    n_checks++;
    if (outs !== 8'b0000_0011) begin n_fail++; $display("FAIL alu_rewrite_issue: got %b want %b", outs, 8'b0000_0011); end
    @(negedge clk); set_idle(); #1;
    n_checks++;
    if (outs !== 8'b0000_0000) begin n_fail++; $display("FAIL alu_drain: got %b want %b", outs, 8'b0000_0000); end
  endtask

  task automatic test_x0_clamp();
    int stalls;
    @(negedge clk); drive_id(1, 0, 0, 0, 0, 0, 1, 2); #1;
    n_checks++;
    if (outs !== 8'b0000_0010) begin n_fail++; $display("FAIL x0_issue: got %b want %b", outs, 8'b0000_0010); end
    @(negedge clk); set_idle(); #1;
    n_checks++;
    if (outs !== 8'b0000_0000) begin n_fail++; $display("FAIL x0_not_busy: got %b want %b", outs, 8'b0000_0000); end
    @(negedge clk); drive_id(1, 0, 0, 0, 0, 7, 1, 7); #1;
    n_checks++;
    if (outs !== 8'b0000_0010) begin n_fail++; $display("FAIL clamp_issue_prod: got %b want %b", outs, 8'b0000_0010); end
    stalls = 0;
    @(negedge clk); drive_id(1, 7, 1, 0, 0, 0, 0, 1); #1;
    for (int i = 0; i < 8 && stall_if === 1'b1; i++) begin
      stalls++;
      @(negedge clk); #1;
    end
    n_checks++;
    if (stalls != 3) begin n_fail++; $display("FAIL clamp_stall_cycles: got %0d want %0d", stalls, 3); end
    n_checks++;
    if (outs !== 8'b0000_0011) begin n_fail++; $display("FAIL clamp_consumer_issue: got %b want %b", outs, 8'b0000_0011); end
    // id_lat = 0 acts as latency 1: forwardable next cycle, still busy.
    @(negedge clk); drive_id(1, 0, 0, 0, 0, 8, 1, 0); #1;
    n_checks++;
    if (outs !== 8'b0000_0010) begin n_fail++; $display("FAIL lat0_issue_prod: got %b want %b", outs, 8'b0000_0010); end
    @(negedge clk); drive_id(1, 8, 1, 0, 0, 0, 0, 1); #1;
    n_checks++;
    if (outs !== 8'b0000_0011) begin n_fail++; $display("FAIL lat0_consumer: got %b want %b", outs, 8'b0000_0011); end
    @(negedge clk); set_idle(); #1;
    n_checks++;
    if (outs !== 8'b0000_0000) begin n_fail++; $display("FAIL lat0_drain: got %b want %b", outs, 8'b0000_0000); end
  endtask

  task automatic test_redirect();
    @(negedge clk); drive_id(1, 0, 0, 0, 0, 5, 1, 2); #1;
    n_checks++;
    if (outs !== 8'b0000_0010) begin n_fail++; $display("FAIL rd_issue_prod: got %b want %b", outs, 8'b0000_0010); end
    @(negedge clk); drive_id(1, 5, 1, 0, 0, 12, 1, 3); ex_redirect = 1'b1; #1;
    n_checks++;
    if (outs !== 8'b0001_1001) begin n_fail++; $display("FAIL rd_flush: got %b want %b", outs, 8'b0001_1001); end
    @(negedge clk); ex_redirect = 1'b0; drive_id(1, 12, 1, 0, 0, 0, 0, 1); #1;
    n_checks++;
    if (outs !== 8'b0000_0011) begin n_fail++; $display("FAIL rd_no_load: got %b want %b", outs, 8'b0000_0011); end
    @(negedge clk); set_idle(); #1;
    n_checks++;
    if (outs !== 8'b0000_0000) begin n_fail++; $display("FAIL rd_drain: got %b want %b", outs, 8'b0000_0000); end
  endtask

  task automatic test_freeze();
    @(negedge clk); drive_id(1, 0, 0, 0, 0, 5, 1, 2); #1;
    n_checks++;
    if (outs !== 8'b0000_0010) begin n_fail++; $display("FAIL fz_issue_prod: got %b want %b", outs, 8'b0000_0010); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_id(1, 0, 0, 0, 0, 13, 1, 1);
      mem_req = 1'b1; mem_ack = 1'b0; ex_redirect = (i == 2); #1;
      n_checks++;
      if (outs !== 8'b1100_0101) begin n_fail++; $display("FAIL fz_hold_%0d: got %b want %b", i, outs, 8'b1100_0101); end
    end
    @(negedge clk); ex_redirect = 1'b0; mem_ack = 1'b1; drive_id(1, 5, 1, 0, 0, 0, 0, 1); #1;
    n_checks++;
    if (outs !== 8'b1110_0001) begin n_fail++; $display("FAIL fz_ack_stall: got %b want %b", outs, 8'b1110_0001); end
    @(negedge clk); mem_req = 1'b0; mem_ack = 1'b0; drive_id(1, 5, 1, 13, 1, 0, 0, 1); #1;
    n_checks++;
    if (outs !== 8'b0000_0011) begin n_fail++; $display("FAIL fz_after_issue: got %b want %b", outs, 8'b0000_0011); end
    @(negedge clk); set_idle(); #1;
    n_checks++;
    if (outs !== 8'b0000_0000) begin n_fail++; $display("FAIL fz_drain: got %b want %b", outs, 8'b0000_0000); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); drive_id(1, 0, 0, 0, 0, 9, 1, 3); #1;
    n_checks++;
    if (outs !== 8'b0000_0010) begin n_fail++; $display("FAIL ar_issue_prod: got %b want %b", outs, 8'b0000_0010); end
    @(negedge clk); set_idle(); #1;
    n_checks++;
    if (outs !== 8'b0000_0001) begin n_fail++; $display("FAIL ar_busy_before: got %b want %b", outs, 8'b0000_0001); end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (outs !== 8'b0000_0000) begin n_fail++; $display("FAIL ar_cleared: got %b want %b", outs, 8'b0000_0000); end
    @(negedge clk); reset = 1'b1; drive_id(1, 9, 1, 0, 0, 0, 0, 1); #1;
    n_checks++;
    if (outs !== 8'b0000_0010) begin n_fail++; $display("FAIL ar_consumer_issue: got %b want %b", outs, 8'b0000_0010); end
    @(negedge clk); set_idle(); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_load_use();
    test_alu_back_to_back();
    test_x0_clamp();
    test_redirect();
    test_freeze();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
